fp_multiplication: RTL and testbench

// - Mantissa-multiply and normalise stage of the single-precision FP multiplier.
// - Sits after fp_mul pre-processing, which supplies the two 24-bit significands
//   (hidden bit included) and the provisional biased exponent.
// - Produces the 23-bit result fraction and the final 8-bit biased exponent.
// - Two-stage pipeline with IEEE-754 round-to-nearest-even; sign handling is upstream.

---
 rtl/fp_multiplication.sv | 98 +++++++++
 tb/tb_fp_multiplication.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/fp_multiplication.sv
// Single-precision significand multiply, normalise and round-to-nearest-even stage.
// Latency: 2 core cycles from inputs to fraction/exponent while sel2 stays low.
// Backpressure: none; sel2=1 freezes both pipeline stages so outputs hold.
module fp_multiplication (
    input  logic        clk,
    input  logic        rstn,
    input  logic        sel2,
    input  logic [23:0] Shifted_val,
    input  logic [23:0] nonShifted_val,
    input  logic [7:0]  exponent_temp,
    output logic [22:0] fraction,
    output logic [7:0]  exponent
);

    // Stage 1 state: raw product, provisional exponent, zero flag
    logic [47:0] prod_q, prod_d;
    logic [7:0]  et_q, et_d;
    logic        zero_q, zero_d;

    // Stage 2 state: rounded result
    logic [22:0] frac_q, frac_d;
    logic [7:0]  exp_q, exp_d;

    // Stage 2 intermediates
    logic [22:0] mant_n;
    logic        guard;
    logic        sticky;
    logic        round_up;
    logic [23:0] mant_r;
    logic [8:0]  exp_n;
    logic [8:0]  exp_r;

    // Stage 1 next state: full-width unsigned product and zero detection
    always_comb begin
        prod_d = {24'd0, Shifted_val} * {24'd0, nonShifted_val};
        et_d   = exponent_temp;
        zero_d = (Shifted_val == 24'd0) | (nonShifted_val == 24'd0) |
                 (exponent_temp == 8'd0);
    end

    // Stage 1 register; holds while the unit is idle
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            prod_q <= '0;
            et_q   <= '0;
            zero_q <= 1'b0;
        end else if (!sel2) begin
            prod_q <= prod_d;
            et_q   <= et_d;
            zero_q <= zero_d;
        end
    end

    // Stage 2 next state: normalise on the product MSB, round to nearest even,
    // renormalise on round carry, then apply zero flush and overflow saturation
    always_comb begin
        if (prod_q[47]) begin
            mant_n = prod_q[46:24];
            guard  = prod_q[23];
            sticky = |prod_q[22:0];
        end else begin
            mant_n = prod_q[45:23];
            guard  = prod_q[22];
            sticky = |prod_q[21:0];
        end
        exp_n    = {1'b0, et_q} + {8'd0, prod_q[47]};
        round_up = guard & (sticky | mant_n[0]);
        // A carry out of bit 22 leaves the low 23 bits at zero, which is the
        // renormalised fraction; only the exponent needs bumping.
        mant_r   = {1'b0, mant_n} + {23'd0, round_up};
        exp_r    = exp_n + {8'd0, mant_r[23]};

        frac_d = mant_r[22:0];
        exp_d  = exp_r[7:0];
        if (zero_q) begin
            frac_d = '0;
            exp_d  = '0;
        end else if (exp_r >= 9'd255) begin
            frac_d = '0;
            exp_d  = 8'hFF;
        end
    end

    // Stage 2 register; frozen together with stage 1 so outputs hold
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            frac_q <= '0;
            exp_q  <= '0;
        end else if (!sel2) begin
            frac_q <= frac_d;
            exp_q  <= exp_d;
        end
    end

    assign fraction = frac_q;
    assign exponent = exp_q;

endmodule

// File: tb/tb_fp_multiplication.sv
// Directed and random stimulus for the FP significand multiply/round stage.
// Latency: expectations queued at drive time, compared two edges later.
// Backpressure: sel2 hold phases push nothing and check that outputs freeze.
module tb_fp_multiplication;

    logic        clk = 1'b0;
    logic        rstn = 1'b1;
    logic        sel2 = 1'b0;
    logic [23:0] a_dat = '0;
    logic [23:0] b_dat = '0;
    logic [7:0]  et_dat = '0;
    logic [22:0] fraction;
    logic [7:0]  exponent;

    int checks = 0;
    int errors = 0;
    int item_id = 0;

    typedef struct {
        bit          chk;
        int          id;
        logic [22:0] frac;
        logic [7:0]  expo;
    } exp_t;

    exp_t sbq[$];

    fp_multiplication dut (
        .clk            (clk),
        .rstn           (rstn),
        .sel2           (sel2),
        .Shifted_val    (a_dat),
        .nonShifted_val (b_dat),
        .exponent_temp  (et_dat),
        .fraction       (fraction),
        .exponent       (exponent)
    );

    always #5 clk = ~clk;

    // Reference: integer significand = product >> shift, remainder compared
    // against one half ulp, overflowing significand renormalised by one bit.
    function automatic logic [30:0] ref_mul(input logic [23:0] a,
                                            input logic [23:0] b,
                                            input logic [7:0]  et);
        logic [47:0] p;
        logic [47:0] q;
        logic [47:0] rem;
        logic [47:0] half;
        int          sh;
        int          e;
        if (a == 0 || b == 0 || et == 0) return '0;
        p    = {24'd0, a} * {24'd0, b};
        sh   = p[47] ? 24 : 23;
        e    = int'(et) + (p[47] ? 1 : 0);
        q    = p >> sh;
        rem  = p & ((48'd1 << sh) - 48'd1);
        half = 48'd1 << (sh - 1);
        if (rem > half || (rem == half && q[0])) q = q + 48'd1;
        if (q[24]) begin
            q = q >> 1;
            e = e + 1;
        end
        if (e >= 255) return {8'hFF, 23'd0};
        return {e[7:0], q[22:0]};
    endfunction

    task automatic check(input string tag, input logic [22:0] got_f,
                         input logic [7:0] got_e, input logic [22:0] exp_f,
                         input logic [7:0] exp_e);
        checks++;
        assert ({got_f, got_e} === {exp_f, exp_e}) else begin
            errors++;
            $error("FAIL %s: got fraction=%h exponent=%h, expected fraction=%h exponent=%h",
                   tag, got_f, got_e, exp_f, exp_e);
        end
    endtask

    // One active cycle: drive, queue expectation, clock, compare the item due now
    task automatic step(input logic [23:0] a, input logic [23:0] b,
                        input logic [7:0] et, input bit chk,
                        input logic [22:0] ef, input logic [7:0] ee);
        exp_t it;
        exp_t due;
        sel2   = 1'b0;
        a_dat  = a;
        b_dat  = b;
        et_dat = et;
        it.chk  = chk;
        it.id   = item_id++;
        it.frac = ef;
        it.expo = ee;
        sbq.push_back(it);
        @(posedge clk);
        #1;
        if (sbq.size() == 2) begin
            due = sbq.pop_front();
            if (due.chk) check($sformatf("item%0d", due.id), fraction, exponent,
                               due.frac, due.expo);
        end
    endtask

    task automatic step_model(input logic [23:0] a, input logic [23:0] b,
                              input logic [7:0] et);
        logic [30:0] r;
        r = ref_mul(a, b, et);
        step(a, b, et, 1'b1, r[22:0], r[30:23]);
    endtask

    initial begin
        logic [23:0] ra;
        logic [23:0] rb;
        logic [7:0]  re;

        // Asynchronous reset with arbitrary inputs, before any clock edge
        a_dat  = $urandom_range(24'hFFFFFF, 24'h800000);
        b_dat  = $urandom_range(24'hFFFFFF, 24'h800000);
        et_dat = 8'd77;
        #1 rstn = 1'b0;
        #1;
        check("reset_async", fraction, exponent, 23'd0, 8'd0);
        repeat (2) @(posedge clk);
        #1;
        check("reset_held", fraction, exponent, 23'd0, 8'd0);
        @(negedge clk);
        rstn = 1'b1;
        @(posedge clk);
        #1;

        // Directed values with hand-derived results
        step(24'h800000, 24'h800000, 8'd127, 1'b1, 23'h000000, 8'd127);
        step(24'hC00000, 24'hC00000, 8'd128, 1'b1, 23'h100000, 8'd129);
        step(24'hFFFFFF, 24'hFFFFFF, 8'd100, 1'b1, 23'h7FFFFE, 8'd101);
        step(24'h800001, 24'hC00000, 8'd127, 1'b1, 23'h400002, 8'd127);
        step(24'hC00000, 24'h000000, 8'd130, 1'b1, 23'h000000, 8'd0);
        step(24'h000000, 24'hA00000, 8'd130, 1'b1, 23'h000000, 8'd0);
        step(24'hC00000, 24'hC00000, 8'd0,   1'b1, 23'h000000, 8'd0);
        step(24'hFFFFFF, 24'h800001, 8'd50,  1'b1, 23'h000000, 8'd51);
        step(24'h800000, 24'h800000, 8'd255, 1'b1, 23'h000000, 8'hFF);
        step_model(24'hB504F3, 24'hB504F3, 8'd127);
        step_model(24'hB504F4, 24'hB504F3, 8'd126);

        // Back-to-back random significands and exponents
        for (int i = 0; i < 24; i++) begin
            ra = $urandom_range(24'hFFFFFF, 24'h800000);
            rb = $urandom_range(24'hFFFFFF, 24'h800000);
            re = $urandom_range(254, 1);
            step_model(ra, rb, re);
        end
        step(24'h0, 24'h0, 8'd0, 1'b0, '0, '0);

        // Reset in the middle of a burst discards everything in flight
        a_dat  = 24'hC00000;
        b_dat  = 24'hC00000;
        et_dat = 8'd140;
        @(posedge clk);
        #2;
        rstn = 1'b0;
        #1;
        check("reset_midop", fraction, exponent, 23'd0, 8'd0);
        sbq.delete();
        @(negedge clk);
        rstn = 1'b1;
        a_dat  = 24'hE00000;
        b_dat  = 24'hE00000;
        et_dat = 8'd90;
        @(posedge clk);
        #1;
        check("post_reset_no_stale", fraction, exponent, 23'd0, 8'd0);
        sbq.delete();
        step_model(24'hE00000, 24'hE00000, 8'd90);
        step_model(24'h9ABCDE, 24'hF01234, 8'd10);

        // Overflow, loaded twice so both stages agree before holding
        step(24'hC00000, 24'hC00000, 8'd254, 1'b1, 23'h000000, 8'hFF);
        step(24'hC00000, 24'hC00000, 8'd254, 1'b1, 23'h000000, 8'hFF);
        step(24'hC00000, 24'hC00000, 8'd254, 1'b1, 23'h000000, 8'hFF);
        check("overflow_out", fraction, exponent, 23'd0, 8'hFF);

        // Idle: inputs churn, outputs must not move
        for (int i = 0; i < 3; i++) begin
            sel2   = 1'b1;
            a_dat  = $urandom_range(24'hFFFFFF, 24'h800000);
            b_dat  = $urandom_range(24'hFFFFFF, 24'h800000);
            et_dat = $urandom_range(120, 1);
            @(posedge clk);
            #1;
            check($sformatf("hold%0d", i), fraction, exponent, 23'd0, 8'hFF);
        end

        // Resume and drain
        step_model(24'hAAAAAA, 24'h855555, 8'd60);
        step_model(24'hFFFFFE, 24'h800003, 8'd200);
        step(24'h0, 24'h0, 8'd0, 1'b0, '0, '0);
        step(24'h0, 24'h0, 8'd0, 1'b0, '0, '0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
